// File: rtl/decode_dispatch_buffer_pkg.sv
// Shared defaults, station-class constants and payload type for the
// decode-to-dispatch buffer.
package decode_dispatch_buffer_pkg;
  localparam int DEF_DEPTH     = 4;
  localparam int DEF_PAYLOAD_W = 128;
  localparam int DEF_NUM_RS    = 2;
  localparam int DEF_RS_W      = 2;
  localparam int DEF_CNT_W     = 16;

  localparam int ALU_RS    = 0;
  localparam int BRANCH_RS = 1;

  typedef logic [DEF_PAYLOAD_W-1:0] decodedInstr_t;
endpackage

// File: rtl/decode_dispatch_buffer_if.sv
// Decode-side enqueue and dispatch-side handshake bundle of the buffer.
interface decode_dispatch_buffer_if
  import decode_dispatch_buffer_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int PAYLOAD_W = DEF_PAYLOAD_W,
  parameter int NUM_RS    = DEF_NUM_RS,
  parameter int RS_W      = DEF_RS_W,
  parameter int CNT_W     = DEF_CNT_W
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic                 inValid;
  logic [PAYLOAD_W-1:0] inPayload;
  logic [RS_W-1:0]      inStation;
  logic                 inReady;
  logic                 freeze;
  logic [NUM_RS-1:0]    rsFull;
  logic                 robFull;
  logic                 outValid;
  logic [PAYLOAD_W-1:0] outPayload;
  logic [RS_W-1:0]      outStation;
  logic                 dispatch;
  logic [CW-1:0]        count;
  logic [CNT_W-1:0]     stallCount;

  modport master (
    output inValid, inPayload, inStation, rsFull, robFull,
    input  inReady, freeze, outValid, outPayload, outStation, dispatch, count, stallCount
  );
  modport slave (
    input  inValid, inPayload, inStation, rsFull, robFull,
    output inReady, freeze, outValid, outPayload, outStation, dispatch, count, stallCount
  );
endinterface

// File: rtl/decode_dispatch_buffer_dispatch_fifo_mem.sv
// Entry storage: one write port, asynchronous read so the head is visible
// the cycle after it is written. Contents are intentionally not reset.
module dispatch_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 130
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/decode_dispatch_buffer.sv
// Decode-to-dispatch buffer: circular FIFO whose head issues once the ROB
// and the head's reservation-station class can take it.
module decode_dispatch_buffer
  import decode_dispatch_buffer_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int PAYLOAD_W = DEF_PAYLOAD_W,
  parameter int NUM_RS    = DEF_NUM_RS,
  parameter int RS_W      = DEF_RS_W,
  parameter int CNT_W     = DEF_CNT_W
) (
  input logic clk,
  input logic globalResetN,
  input logic flush,
  decode_dispatch_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  logic [PTR_W-1:0]          head, tail;
  logic [CW-1:0]             cnt;
  logic [CNT_W-1:0]          stall_q;
  logic                      enq, deq, st_full, blocked, stall_inc;
  logic [PAYLOAD_W+RS_W-1:0] rd_word;

  dispatch_fifo_mem #(.DEPTH(DEPTH), .WIDTH(PAYLOAD_W + RS_W)) u_mem (
    .clk   (clk),
    .we    (enq),
    .waddr (tail),
    .wdata ({bus.inStation, bus.inPayload}),
    .raddr (head),
    .rdata (rd_word)
  );

  // Station ids at or above NUM_RS need no station, so only in-range ids
  // can select a full flag.
  always_comb begin
    st_full = 1'b0;
    for (int i = 0; i < NUM_RS; i++)
      if (bus.outStation == RS_W'(i)) st_full = bus.rsFull[i];
  end

  assign blocked        = bus.robFull || st_full;
  assign bus.inReady    = (cnt < CW'(DEPTH)) && !flush;
  assign bus.freeze     = !bus.inReady;
  assign bus.outValid   = (cnt != '0);
  assign bus.outPayload = rd_word[PAYLOAD_W-1:0];
  assign bus.outStation = rd_word[PAYLOAD_W+RS_W-1:PAYLOAD_W];
  assign bus.dispatch   = bus.outValid && !blocked && !flush;
  assign bus.count      = cnt;
  assign bus.stallCount = stall_q;

  assign enq       = bus.inValid && bus.inReady;
  assign deq       = bus.dispatch;
  assign stall_inc = bus.outValid && blocked && !flush && (stall_q != '1);

  always_ff @(posedge clk or negedge globalResetN) begin
    if (!globalResetN) begin
      head    <= '0;
      tail    <= '0;
      cnt     <= '0;
      stall_q <= '0;
    end else begin
      if (flush) begin
        head <= '0;
        tail <= '0;
        cnt  <= '0;
      end else begin
        if (enq) tail <= tail + PTR_W'(1);
        if (deq) head <= head + PTR_W'(1);
        cnt <= cnt + CW'(enq) - CW'(deq);
      end
      if (stall_inc) stall_q <= stall_q + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_decode_dispatch_buffer.sv
// Bench for decode_dispatch_buffer: vector table, directed corner sequences
// and random traffic against a queue-based reference model.
module tb_decode_dispatch_buffer;
  import decode_dispatch_buffer_pkg::*;

  localparam int DEPTH = 4;
  localparam int PW    = 128;
  localparam int NRS   = 2;
  localparam int RSW   = 2;
  localparam int CNTW  = 4;
  localparam int SMAX  = (1 << CNTW) - 1;

  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  always #5 clk = ~clk;

  decode_dispatch_buffer_if #(.DEPTH(DEPTH), .PAYLOAD_W(PW), .NUM_RS(NRS), .RS_W(RSW), .CNT_W(CNTW)) bus ();

  decode_dispatch_buffer #(.DEPTH(DEPTH), .PAYLOAD_W(PW), .NUM_RS(NRS), .RS_W(RSW), .CNT_W(CNTW)) dut (
    .clk          (clk),
    .globalResetN (rst_n),
    .flush        (flush),
    .bus          (bus)
  );

  typedef struct {
    decodedInstr_t   pl;
    logic [RSW-1:0]  st;
  } ent_t;

  typedef struct {
    logic            iv;
    decodedInstr_t   pl;
    logic [RSW-1:0]  st;
    logic [NRS-1:0]  rsf;
    logic            rob;
    logic            fl;
    logic            rdy;
    logic            ov;
    logic            disp;
    int              cnt;
    decodedInstr_t   epl;
  } vec_t;

  ent_t mq[$];
  int   stall_m = 0;
  int   nchk = 0, nerr = 0;

  task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: drive at posedge+1, check at negedge, advance model at posedge.
  task automatic step(input logic iv, input decodedInstr_t pl, input logic [RSW-1:0] st,
                      input logic [NRS-1:0] rsf, input logic rob, input logic fl,
                      output logic o_rdy, output logic o_ov, output logic o_disp,
                      output int o_cnt, output decodedInstr_t o_pl);
    logic e_rdy, e_ov, e_disp, blk;
    ent_t h;
    bus.inValid = iv; bus.inPayload = pl; bus.inStation = st;
    bus.rsFull = rsf; bus.robFull = rob; flush = fl;
    @(negedge clk);
    e_rdy = (mq.size() < DEPTH) && !fl;
    e_ov  = (mq.size() != 0);
    blk   = rob;
    h     = '{pl: '0, st: '0};
    if (e_ov) begin
      h = mq[0];
      if (int'(h.st) < NRS) if (rsf[h.st]) blk = 1'b1;
    end
    e_disp = e_ov && !blk && !fl;
    chk("inReady", bus.inReady, e_rdy);
    chk("freeze", bus.freeze, !e_rdy);
    chk("outValid", bus.outValid, e_ov);
    chk("dispatch", bus.dispatch, e_disp);
    chk("count", bus.count, mq.size());
    chk("stallCount", bus.stallCount, stall_m);
    if (e_ov) begin
      chk("outPayload", bus.outPayload, h.pl);
      chk("outStation", bus.outStation, h.st);
    end
    o_rdy = bus.inReady; o_ov = bus.outValid; o_disp = bus.dispatch;
    o_cnt = int'(bus.count); o_pl = bus.outPayload;
    @(posedge clk);
    if (fl) mq.delete();
    else begin
      if (e_disp) void'(mq.pop_front());
      if (iv && e_rdy) mq.push_back('{pl: pl, st: st});
    end
    if (e_ov && blk && !fl && stall_m < SMAX) stall_m++;
    #1;
  endtask

  task automatic sd(input logic iv, input decodedInstr_t pl, input logic [RSW-1:0] st,
                    input logic [NRS-1:0] rsf, input logic rob, input logic fl);
    logic a, b, c; int n; decodedInstr_t p;
    step(iv, pl, st, rsf, rob, fl, a, b, c, n, p);
  endtask

  vec_t tv[13];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic r, v, d; int c; decodedInstr_t p; int sb;

    tv[0]  = '{1, 'hA1, 0, 0, 1, 0,  1, 0, 0, 0, 0};
    tv[1]  = '{1, 'hA2, 1, 0, 1, 0,  1, 1, 0, 1, 'hA1};
    tv[2]  = '{1, 'hA3, 3, 0, 1, 0,  1, 1, 0, 2, 'hA1};
    tv[3]  = '{1, 'hA4, 0, 0, 1, 0,  1, 1, 0, 3, 'hA1};
    tv[4]  = '{1, 'hA5, 0, 0, 1, 0,  0, 1, 0, 4, 'hA1};
    tv[5]  = '{1, 'hA5, 0, 0, 0, 0,  0, 1, 1, 4, 'hA1};
    tv[6]  = '{0, 0,    0, 0, 0, 0,  1, 1, 1, 3, 'hA2};
    tv[7]  = '{0, 0,    0, 3, 0, 0,  1, 1, 1, 2, 'hA3};
    tv[8]  = '{0, 0,    0, 1, 0, 0,  1, 1, 0, 1, 'hA4};
    tv[9]  = '{0, 0,    0, 2, 0, 0,  1, 1, 1, 1, 'hA4};
    tv[10] = '{0, 0,    0, 0, 1, 0,  1, 0, 0, 0, 0};
    tv[11] = '{1, 'hA6, 0, 0, 0, 1,  0, 0, 0, 0, 0};
    tv[12] = '{0, 0,    0, 0, 0, 0,  1, 0, 0, 0, 0};

    bus.inValid = 0; bus.inPayload = '0; bus.inStation = '0;
    bus.rsFull = '0; bus.robFull = 0;
    #2;
    chk("rst_inReady", bus.inReady, 1'b1);
    chk("rst_freeze", bus.freeze, 1'b0);
    chk("rst_outValid", bus.outValid, 1'b0);
    chk("rst_dispatch", bus.dispatch, 1'b0);
    chk("rst_count", bus.count, 0);
    chk("rst_stallCount", bus.stallCount, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill/drain, per-class and no-station blocking, empty, flush.
    for (int i = 0; i < 13; i++) begin
      step(tv[i].iv, tv[i].pl, tv[i].st, tv[i].rsf, tv[i].rob, tv[i].fl, r, v, d, c, p);
      chk($sformatf("vec%0d_rdy", i), r, tv[i].rdy);
      chk($sformatf("vec%0d_ov", i), v, tv[i].ov);
      chk($sformatf("vec%0d_disp", i), d, tv[i].disp);
      chk($sformatf("vec%0d_cnt", i), c, tv[i].cnt);
      if (tv[i].ov) chk($sformatf("vec%0d_pl", i), p, tv[i].epl);
    end

    // Branch-class head blocked for 3 cycles, then released.
    sd(1, 'hB1, 1, 2'b10, 0, 0);
    sb = stall_m;
    for (int i = 0; i < 3; i++) begin
      step(0, '0, 0, 2'b10, 0, 0, r, v, d, c, p);
      chk("blk_disp", d, 1'b0);
    end
    chk("blk_stall3", bus.stallCount, sb + 3);
    step(0, '0, 0, 2'b00, 0, 0, r, v, d, c, p);
    chk("blk_release", d, 1'b1);

    // No-station entry ignores rsFull but not robFull.
    sd(1, 'hC1, 3, 2'b11, 1, 0);
    step(0, '0, 0, 2'b11, 1, 0, r, v, d, c, p);
    chk("nost_rob", d, 1'b0);
    step(0, '0, 0, 2'b11, 0, 0, r, v, d, c, p);
    chk("nost_go", d, 1'b1);

    // Wrap-around at count 3.
    for (int i = 0; i < 3; i++) sd(1, PW'(32'hD00 + i), 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      step(1, PW'(32'hD10 + i), RSW'(i), 0, 0, 0, r, v, d, c, p);
      chk("wrap_cnt", c, 3);
    end
    for (int i = 0; i < 3; i++) sd(0, '0, 0, 0, 0, 0);

    // Flush while full with a pending instruction.
    for (int i = 0; i < 4; i++) sd(1, PW'(32'hE00 + i), 0, 2'b01, 0, 0);
    sb = stall_m;
    step(1, 'hEFF, 0, 2'b01, 0, 1, r, v, d, c, p);
    chk("flush_rdy", r, 1'b0);
    step(0, '0, 0, 2'b01, 0, 0, r, v, d, c, p);
    chk("flush_cnt", c, 0);
    chk("flush_ov", v, 1'b0);
    chk("flush_stall", bus.stallCount, sb);

    // Asynchronous reset between edges with two entries held.
    sd(1, 'hF1, 0, 0, 1, 0);
    sd(1, 'hF2, 0, 0, 1, 0);
    bus.inValid = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", bus.count, 0);
    chk("arst_ov", bus.outValid, 1'b0);
    chk("arst_stall", bus.stallCount, 0);
    chk("arst_rdy", bus.inReady, 1'b1);
    mq.delete(); stall_m = 0;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    sd(1, 'hF3, 0, 0, 1, 0);
    step(0, '0, 0, 0, 0, 0, r, v, d, c, p);
    chk("arst_first", p, PW'('hF3));

    // Stall counter saturation.
    sd(1, 'h51, 0, 0, 1, 0);
    for (int i = 0; i < SMAX + 3; i++) sd(0, '0, 0, 0, 1, 0);
    chk("stall_sat", bus.stallCount, SMAX);
    sd(0, '0, 0, 0, 0, 1);

    // Random traffic against the model.
    for (int i = 0; i < 500; i++)
      sd(($urandom % 4) != 0, {$urandom, $urandom, $urandom, $urandom}, RSW'($urandom % 4),
         NRS'($urandom), ($urandom % 4) == 0, ($urandom % 25) == 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
